xrv1_iqueue: RTL

XRV1_IQUEUE -- requirements
Module: xrv1_iqueue

---
 rtl/xrv1_iqueue.sv | 119 +++++++++++
 1 files changed

// File: rtl/xrv1_iqueue.sv
// In-flight instruction queue: circular buffer of issued tags with per-source producer conflict masks.
// Optional flush port enabled by defining XRV1_IQUEUE_FLUSH_EN.
module xrv1_iqueue #(
  parameter int ITAG_WIDTH_P = 3,
  parameter int rf_addr_width_p = 5,
  localparam int iqueue_size_lp = 1 << ITAG_WIDTH_P,
  localparam int num_rs_lp = 2
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
`ifdef XRV1_IQUEUE_FLUSH_EN
  input  logic                                             flush_i,
`endif
  input  logic                                             issue_vld_i,
  output logic                                             issue_rdy_o,
  input  logic                                             issue_rd_vld_i,
  input  logic [rf_addr_width_p-1:0]                       issue_rd_addr_i,
  input  logic [num_rs_lp-1:0][rf_addr_width_p-1:0]        issue_rs_addr_i,
  output logic [ITAG_WIDTH_P-1:0]                          issue_itag_o,
  output logic [ITAG_WIDTH_P-1:0]                          retire_itag_o,
  input  logic [ITAG_WIDTH_P-1:0]                          retire_cnt_i,
  output logic [iqueue_size_lp-1:0]                        iqueue_vld_o,
  output logic [iqueue_size_lp-1:0]                        iqueue_rd_vld_o,
  output logic [iqueue_size_lp-1:0][rf_addr_width_p-1:0]   iqueue_rd_addr_o,
  output logic [num_rs_lp-1:0][iqueue_size_lp-1:0]         rs_conflict_o,
  output logic [ITAG_WIDTH_P:0]                            count_o
);

  localparam logic [ITAG_WIDTH_P:0] size_c = (ITAG_WIDTH_P+1)'(iqueue_size_lp);

  logic [ITAG_WIDTH_P-1:0]                        head_r, tail_r, head_n_s, tail_n_s;
  logic [ITAG_WIDTH_P:0]                          count_r, count_n_s, retire_clamp_s;
  logic [iqueue_size_lp-1:0]                      vld_r, vld_n_s, rd_vld_r, rd_vld_n_s;
  logic [iqueue_size_lp-1:0]                      retire_mask_s, issue_sel_s;
  logic [iqueue_size_lp-1:0][rf_addr_width_p-1:0] rd_addr_r, rd_addr_n_s;
  logic                                           issue_acc_s;

  // Readiness depends on registered occupancy only; a flush also blocks issue.
`ifdef XRV1_IQUEUE_FLUSH_EN
  assign issue_rdy_o = (count_r < size_c) & ~flush_i;
`else
  assign issue_rdy_o = (count_r < size_c);
`endif

  assign issue_acc_s    = issue_vld_i & issue_rdy_o;
  assign retire_clamp_s = ({1'b0, retire_cnt_i} > count_r) ? count_r : {1'b0, retire_cnt_i};

  // Next-state: entries within N of head are retired, tail slot takes the accepted issue.
  always_comb begin
    logic [ITAG_WIDTH_P-1:0] offset_v;
    offset_v      = '0;
    retire_mask_s = '0;
    issue_sel_s   = '0;
    rd_vld_n_s    = rd_vld_r;
    rd_addr_n_s   = rd_addr_r;
    for (int k = 0; k < iqueue_size_lp; k++) begin
      offset_v         = ITAG_WIDTH_P'(k) - head_r;
      retire_mask_s[k] = ({1'b0, offset_v} < retire_clamp_s);
      issue_sel_s[k]   = issue_acc_s & (tail_r == ITAG_WIDTH_P'(k));
      rd_vld_n_s[k]    = issue_sel_s[k] ? issue_rd_vld_i  : rd_vld_r[k];
      rd_addr_n_s[k]   = issue_sel_s[k] ? issue_rd_addr_i : rd_addr_r[k];
    end
    head_n_s = head_r + retire_clamp_s[ITAG_WIDTH_P-1:0];
`ifdef XRV1_IQUEUE_FLUSH_EN
    if (flush_i) begin
      vld_n_s   = '0;
      tail_n_s  = head_n_s;
      count_n_s = '0;
    end else begin
      vld_n_s   = (vld_r & ~retire_mask_s) | issue_sel_s;
      tail_n_s  = tail_r + {{(ITAG_WIDTH_P-1){1'b0}}, issue_acc_s};
      count_n_s = count_r + {{ITAG_WIDTH_P{1'b0}}, issue_acc_s} - retire_clamp_s;
    end
`else
    vld_n_s   = (vld_r & ~retire_mask_s) | issue_sel_s;
    tail_n_s  = tail_r + {{(ITAG_WIDTH_P-1){1'b0}}, issue_acc_s};
    count_n_s = count_r + {{ITAG_WIDTH_P{1'b0}}, issue_acc_s} - retire_clamp_s;
`endif
  end

  // Queue state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_r    <= '0;
      tail_r    <= '0;
      count_r   <= '0;
      vld_r     <= '0;
      rd_vld_r  <= '0;
      rd_addr_r <= '0;
    end else begin
      head_r    <= head_n_s;
      tail_r    <= tail_n_s;
      count_r   <= count_n_s;
      vld_r     <= vld_n_s;
      rd_vld_r  <= rd_vld_n_s;
      rd_addr_r <= rd_addr_n_s;
    end
  end

  // Producer match against registered entries; x0 never conflicts.
  always_comb begin
    rs_conflict_o = '0;
    for (int j = 0; j < num_rs_lp; j++) begin
      for (int k = 0; k < iqueue_size_lp; k++) begin
        rs_conflict_o[j][k] = vld_r[k] & rd_vld_r[k] &
                              (rd_addr_r[k] == issue_rs_addr_i[j]) &
                              (issue_rs_addr_i[j] != {rf_addr_width_p{1'b0}});
      end
    end
  end

  assign issue_itag_o     = tail_r;
  assign retire_itag_o    = head_r;
  assign count_o          = count_r;
  assign iqueue_vld_o     = vld_r;
  assign iqueue_rd_vld_o  = rd_vld_r;
  assign iqueue_rd_addr_o = rd_addr_r;

endmodule
